// File: rtl/gray_counter_updn_pkg.sv
// Shared definitions for the up/down Gray counter: code conversion helpers
// and width-independent terminal constants that users slice to their width.
package gray_pkg;

    // Widest counter the helpers support; callers zero-extend narrower values.
    localparam int GRAY_MAX_W = 32;

    // Terminal values, sliced by each user down to its own width N.
    localparam logic [GRAY_MAX_W-1:0] GRAY_ALL_ONES = '1;
    localparam logic [GRAY_MAX_W-1:0] GRAY_ZERO     = '0;

    // Binary to reflected Gray code; zero-extension leaves the result unchanged.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary by prefix XOR from the MSB down.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_updn_if.sv
// Control and status bundle of the Gray counter. The master side drives the
// count controls; the slave side (the counter) returns the count and flags.
interface gray_counter_updn_if
    import gray_pkg::*;
#(
    parameter int N = 4
);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] out;
    logic [N-1:0] bin;
    logic         wrap;
    logic         tc;

    modport master (
        output en, up, load, load_val,
        input  out, bin, wrap, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output out, bin, wrap, tc
    );
endinterface

// File: rtl/gray_counter_updn_step_logic.sv
// Next-state logic of the Gray counter, computed entirely in binary. Decides
// the next binary value and wrap flag from load/enable/direction, and raises
// the terminal-count flag from the current value and the live direction.
module gray_step_logic
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic [N-1:0] bin_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] next_bin_o,
    output logic         next_wrap_o,
    output logic         tc_o
);
    localparam logic [N-1:0] BIN_MAX  = GRAY_ALL_ONES[N-1:0];
    localparam logic [N-1:0] BIN_ZERO = GRAY_ZERO[N-1:0];
    localparam logic [N-1:0] BIN_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic atMax;
    logic atZero;

    assign atMax  = (bin_i == BIN_MAX);
    assign atZero = (bin_i == BIN_ZERO);

    // Terminal count follows the live direction and ignores the enable.
    assign tc_o = (up_i && atMax) || (!up_i && atZero);

    // Load beats counting; at a terminal value either wrap around or hold.
    always_comb begin
        next_bin_o  = bin_i;
        next_wrap_o = 1'b0;
        if (load_i) begin
            next_bin_o = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (!atMax) begin
                    next_bin_o = bin_i + BIN_ONE;
                end else if (SATURATE == 0) begin
                    next_bin_o  = BIN_ZERO;
                    next_wrap_o = 1'b1;
                end
            end else begin
                if (!atZero) begin
                    next_bin_o = bin_i - BIN_ONE;
                end else if (SATURATE == 0) begin
                    next_bin_o  = BIN_MAX;
                    next_wrap_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/gray_counter_updn.sv
// Parametrised up/down Gray counter. The binary count is the real state; the
// Gray output is a separate register loaded from the converted next value so
// it never glitches and only one bit moves per count step.
module gray_counter_updn
    import gray_pkg::*;
#(
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rstn,
    gray_counter_updn_if.slave bus
);
    logic [N-1:0] bin_q;
    logic [N-1:0] bin_d;
    logic [N-1:0] out_q;
    logic [N-1:0] out_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         tcComb;

    gray_step_logic #(
        .N        (N),
        .SATURATE (SATURATE)
    ) u_step (
        .bin_i       (bin_q),
        .en_i        (bus.en),
        .up_i        (bus.up),
        .load_i      (bus.load),
        .load_val_i  (bus.load_val),
        .next_bin_o  (bin_d),
        .next_wrap_o (wrap_d),
        .tc_o        (tcComb)
    );

    // Gray image of the next binary value, registered alongside it.
    always_comb begin
        out_d = N'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bin_q  <= '0;
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.bin  = bin_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = tcComb;
endmodule

// File: tb/tb_gray_counter_updn.sv
// Bench for the up/down Gray counter. Two instances share clock, reset and
// controls: a 4-bit wrapping one and a 3-bit saturating one. Each directed
// step pushes its hand-computed expectation into a scoreboard queue; a
// monitor drains the queue on the falling edge and compares.
module tb_gray_counter_updn;

    typedef struct {
        int         dut;
        string      name;
        logic [3:0] out;
        logic [3:0] bin;
        logic       wrap;
        logic       tc;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    exp_t sbq[$];

    logic [3:0] upGray   [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] satGray  [10] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [3:0] downBin  [7]  = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0};
    logic [3:0] downGray [7]  = '{4'h7, 4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h0};

    gray_counter_updn_if #(.N(4)) ifA ();
    gray_counter_updn_if #(.N(3)) ifB ();

    gray_counter_updn #(.N(4), .SATURATE(0)) dutA (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifA)
    );

    gray_counter_updn #(.N(3), .SATURATE(1)) dutB (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifB)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compareField(input string name, input string field,
                                input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against queued expectations.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] aOut;
        logic [3:0] aBin;
        logic       aWrap;
        logic       aTc;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.dut == 0) begin
                aOut  = ifA.out;
                aBin  = ifA.bin;
                aWrap = ifA.wrap;
                aTc   = ifA.tc;
            end else begin
                aOut  = {1'b0, ifB.out};
                aBin  = {1'b0, ifB.bin};
                aWrap = ifB.wrap;
                aTc   = ifB.tc;
            end
            compareField(e.name, "out",  aOut, e.out);
            compareField(e.name, "bin",  aBin, e.bin);
            compareField(e.name, "wrap", {3'b0, aWrap}, {3'b0, e.wrap});
            compareField(e.name, "tc",   {3'b0, aTc},   {3'b0, e.tc});
        end
    end

    // Drive one set of controls after a falling edge and let one rising edge pass.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lv);
        @(negedge clk);
        #1;
        rstn         = r;
        ifA.en       = e;
        ifA.up       = u;
        ifA.load     = l;
        ifA.load_val = lv;
        ifB.en       = e;
        ifB.up       = u;
        ifB.load     = l;
        ifB.load_val = lv[2:0];
        @(posedge clk);
        #1;
    endtask

    // Count up across one edge while glitching reset low only between edges.
    task automatic pulseResetMidCycle();
        @(negedge clk);
        #1;
        rstn     = 1'b1;
        ifA.en   = 1'b1;
        ifA.up   = 1'b1;
        ifA.load = 1'b0;
        ifB.en   = 1'b1;
        ifB.up   = 1'b1;
        ifB.load = 1'b0;
        #1 rstn  = 1'b0;
        #1 rstn  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int dut, input string name, input logic [3:0] o,
                               input logic [3:0] b, input logic w, input logic t);
        exp_t e;
        e.dut  = dut;
        e.name = name;
        e.out  = o;
        e.bin  = b;
        e.wrap = w;
        e.tc   = t;
        sbq.push_back(e);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        ifA.en       = 1'b0;
        ifA.up       = 1'b1;
        ifA.load     = 1'b0;
        ifA.load_val = '0;
        ifB.en       = 1'b0;
        ifB.up       = 1'b1;
        ifB.load     = 1'b0;
        ifB.load_val = '0;

        // Reset held across two edges with counting requested.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "rst0", 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput(1, "rst0B", 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "rst1", 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "firstUp", 4'h1, 4'h1, 1'b0, 1'b0);

        // Full up cycle from zero, wrapping on the last step.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "rstUp", 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
            checkOutput(0, $sformatf("up[%0d]", i), upGray[i], 4'(i + 1),
                        (i == 15), (i == 14));
        end

        // Down from zero wraps to all-ones.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput(0, "downWrap", 4'h8, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput(0, "downNext", 4'h9, 4'hE, 1'b0, 1'b0);

        // Load outranks a simultaneous count request.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "rstLoad", 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "cnt1", 4'h1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "cnt2", 4'h3, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "cnt3", 4'h2, 4'h3, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
        checkOutput(0, "loadA", 4'hF, 4'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "afterLoad", 4'hE, 4'hB, 1'b0, 1'b0);

        // Wrap pulse is cleared by a following load and by a following hold.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
        checkOutput(0, "loadF", 4'h8, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "wrapUp", 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
        checkOutput(0, "load5", 4'h7, 4'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
        checkOutput(0, "loadF2", 4'h8, 4'hF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "wrapUp2", 4'h0, 4'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "holdClr", 4'h0, 4'h0, 1'b0, 1'b0);

        // Reset glitch between edges is ignored; reset across an edge clears.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h4);
        checkOutput(0, "load4", 4'h6, 4'h4, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "at5", 4'h7, 4'h5, 1'b0, 1'b0);
        pulseResetMidCycle();
        checkOutput(0, "rstGlitch", 4'h5, 4'h6, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput(0, "rstEdge", 4'h0, 4'h0, 1'b0, 1'b0);

        // Hold for five edges keeps the loaded value.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h9);
        checkOutput(0, "load9", 4'hD, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
            checkOutput(0, $sformatf("hold[%0d]", i), 4'hD, 4'h9, 1'b0, 1'b0);
        end

        // Saturating 3-bit counter: climb and stick at 7 with no wrap.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput(1, "rstSat", 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
            checkOutput(1, $sformatf("satUp[%0d]", i), satGray[i],
                        (i < 7) ? 4'(i + 1) : 4'h7, 1'b0, (i >= 6));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput(1, "satHoldTc", 4'h4, 4'h7, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput(1, "satDirDn", 4'h4, 4'h7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput(1, "satDn6", 4'h5, 4'h6, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
            checkOutput(1, $sformatf("satDn[%0d]", i), downGray[i], downBin[i],
                        1'b0, (downBin[i] == 4'h0));
        end

        // Let the monitor drain, then confirm nothing is left unchecked.
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain actual=%0d expected=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
